// File: rtl/mul_iter_unit_pkg.sv
// Shared state encodings and defaults for the iterative shift-add multiplier.
// The hazard unit imports the same encodings to build its stall.
package mul_iter_unit_pkg;

  localparam int MUL_WIDTH_DEF = 32;

  localparam logic [1:0] MUL_IDLE = 2'b00;
  localparam logic [1:0] MUL_RUN  = 2'b01;
  localparam logic [1:0] MUL_DONE = 2'b10;

  // A new request is only taken when no operation is in flight.
  function automatic logic mul_can_accept(input logic [1:0] state);
    return (state == MUL_IDLE) || (state == MUL_DONE);
  endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Start/busy/done request bus between the EX-stage pipeline (master) and the multiplier (slave).
// Signal suffixes are taken from the multiplier's point of view.
interface mul_iter_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  start_i,
    input  data1_i,
    input  data2_i,
    output data_o,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output data1_i,
    output data2_i,
    input  data_o,
    input  busy_o,
    input  done_o
  );

endinterface

// File: rtl/mul_iter_unit.sv
// Shift-add multiplier returning the low WIDTH bits of data1*data2; fixed WIDTH+1 cycle latency.
// Pipeline stalls on busy_o; start_i is ignored while busy, accepted again in the done cycle.
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_iter_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             accept;
  logic [WIDTH-1:0] acc_step;

  assign accept   = mul_can_accept(state_q) && bus.start_i;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    data_d   = data_q;
    cnt_d    = cnt_q;

    case (state_q)
      MUL_IDLE: ;
      MUL_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The last step's sum goes straight to the output register.
        if (cnt_q == CNT_LAST) begin
          state_d = MUL_DONE;
          data_d  = acc_step;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase

    if (accept) begin
      state_d  = MUL_RUN;
      mcand_d  = bus.data1_i;
      mplier_d = bus.data2_i;
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.busy_o = (state_q == MUL_RUN);
  assign bus.done_o = (state_q == MUL_DONE);

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed and random checks of mul_iter_unit: latency, wrap-around, ignored restarts, reset, back-to-back.
module tb_mul_iter_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mul_iter_unit_if #(.WIDTH(32)) bus ();

  mul_iter_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one request; returns at accept edge + 1ns with operands scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.data1_i = a;
    bus.data2_i = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.data1_i = $urandom;
    bus.data2_i = $urandom;
  endtask

  // Observe until done_o (bounded); reports edges taken, busy cycles and busy/done overlaps.
  task automatic wait_done(output int edges, output int busy_cyc, output int overlaps);
    edges    = 0;
    busy_cyc = 0;
    overlaps = 0;
    while (edges < 100) begin
      if (bus.busy_o && bus.done_o) overlaps++;
      if (bus.done_o) break;
      if (bus.busy_o) busy_cyc++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.data1_i = '0;
    bus.data2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e, b, o;
    start_op(32'd7, 32'd6);
    wait_done(e, b, o);
    checks++; if (e !== 32) begin errors++; $display("FAIL basic_latency got=%0d exp=32", e); end
    checks++; if (b !== 32) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=32", b); end
    checks++; if (o !== 0) begin errors++; $display("FAIL basic_overlap got=%0d exp=0", o); end
    checks++; if (bus.data_o !== 32'd42) begin errors++; $display("FAIL basic_data got=%h exp=%h", bus.data_o, 32'd42); end
    @(posedge clk);
    #1;
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.data_o !== 32'd42) begin errors++; $display("FAIL basic_hold got=%h exp=%h", bus.data_o, 32'd42); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [7] = '{32'hFFFFFFFD, 32'hFFFFFFFC, 32'h80000000, 32'h00000000,
                           32'hFFFFFFFF, 32'h00010000, 32'd12345};
    logic [31:0] vb [7] = '{32'd5,       32'hFFFFFFFC, 32'hFFFFFFFF, 32'h12345678,
                           32'hFFFFFFFF, 32'h00010000, 32'd6789};
    logic [31:0] ve [7] = '{32'hFFFFFFF1, 32'd16,      32'h80000000, 32'h00000000,
                           32'h00000001, 32'h00000000, 32'h04FED79D};
    int e, b, o;
    for (int i = 0; i < 7; i++) begin
      start_op(va[i], vb[i]);
      wait_done(e, b, o);
      checks++; if (bus.data_o !== ve[i]) begin errors++; $display("FAIL vec%0d_data got=%h exp=%h", i, bus.data_o, ve[i]); end
      checks++; if (e !== 32) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=32", i, e); end
      checks++; if (o !== 0) begin errors++; $display("FAIL vec%0d_overlap got=%0d exp=0", i, o); end
    end
  endtask

  task automatic test_ignore_restart();
    int e, b, o, pulses;
    start_op(32'd2, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b1;
    bus.data1_i = 32'd9;
    bus.data2_i = 32'd9;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", bus.busy_o); end
    checks++; if (bus.data_o !== 32'h04FED79D) begin errors++; $display("FAIL ignore_old_result got=%h exp=%h", bus.data_o, 32'h04FED79D); end
    wait_done(e, b, o);
    checks++; if (e !== 22) begin errors++; $display("FAIL ignore_latency got=%0d exp=22", e); end
    checks++; if (bus.data_o !== 32'd6) begin errors++; $display("FAIL ignore_data got=%h exp=%h", bus.data_o, 32'd6); end
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid_run();
    int e, b, o, pulses;
    start_op(32'd5, 32'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.data_o !== 32'd0) begin errors++; $display("FAIL midrst_data got=%h exp=0", bus.data_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_abandoned got=%0d exp=0", pulses); end
    start_op(32'd4, 32'd4);
    wait_done(e, b, o);
    checks++; if (bus.data_o !== 32'd16) begin errors++; $display("FAIL midrst_next_data got=%h exp=%h", bus.data_o, 32'd16); end
    checks++; if (e !== 32) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=32", e); end
  endtask

  task automatic test_back_to_back();
    int e, b, o;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.data1_i = 32'd3;
    bus.data2_i = 32'd3;
    @(posedge clk);
    #1;
    bus.data1_i = 32'd5;
    bus.data2_i = 32'd5;
    wait_done(e, b, o);
    checks++; if (e !== 32) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=32", e); end
    checks++; if (b !== 32) begin errors++; $display("FAIL b2b_first_busy got=%0d exp=32", b); end
    checks++; if (bus.data_o !== 32'd9) begin errors++; $display("FAIL b2b_first_data got=%h exp=%h", bus.data_o, 32'd9); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_busy got=%b exp=1", bus.busy_o); end
    checks++; if (bus.data_o !== 32'd9) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.data_o, 32'd9); end
    wait_done(e, b, o);
    bus.start_i = 1'b0;
    checks++; if (e !== 32) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=32", e); end
    checks++; if (o !== 0) begin errors++; $display("FAIL b2b_overlap got=%0d exp=0", o); end
    checks++; if (bus.data_o !== 32'd25) begin errors++; $display("FAIL b2b_second_data got=%h exp=%h", bus.data_o, 32'd25); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    int e, bc, o;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = $urandom;
      exp = a * b;
      start_op(a, b);
      wait_done(e, bc, o);
      checks++; if (bus.data_o !== exp) begin errors++; $display("FAIL rand%0d_data a=%h b=%h got=%h exp=%h", i, a, b, bus.data_o, exp); end
      checks++; if (o !== 0) begin errors++; $display("FAIL rand%0d_overlap got=%0d exp=0", i, o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_restart();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
